dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_lane_align.sv | 43 ++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_responder data-memory slice.
// Optional tohost mailbox is enabled with DMEM_TOHOST_EN.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    be         = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    shifted    = rword >> {byte_off, 3'b000};
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << byte_off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be         = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        be         = '1;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
      F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the load/store interface: word RAM, wait states, error checks.
// Define DMEM_TOHOST_EN to add the tohost mailbox register at TOHOST_ADDR.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_TOHOST_EN
  ,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state;
  logic [3:0]    cnt;
  logic          started;
  logic          acc;
  logic          illegal;
  logic          misalign;
  logic          oor;
  logic          th_hit;
  logic          req_err;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rword;
  logic [31:0]   rext;

  // started keeps req_ready low until the first edge after reset release
  assign req_ready = started && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign acc       = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];

  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = req_we;
      default:          illegal = 1'b1;
    endcase
    misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
            || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    oor      = (req_addr[31:AW+2] != '0)
            && !(th_hit && (!req_we || (req_funct3 == F3_W)));
    req_err  = illegal || misalign || oor;
  end

`ifdef DMEM_TOHOST_EN
  assign th_hit = (req_addr[31:2] == TOHOST_ADDR[31:2]);
  assign rword  = th_hit ? tohost_data : mem[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else begin
      tohost_valid <= acc && req_we && th_hit && !req_err;
      if (acc && req_we && th_hit && !req_err) tohost_data <= req_wdata;
    end
  end
`else
  assign th_hit = 1'b0;
  assign rword  = mem[idx];
`endif

  dmem_lane_align u_align (
    .funct3     (req_funct3),
    .byte_off   (req_addr[1:0]),
    .wdata      (req_wdata),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wlane),
    .rdata_ext  (rext)
  );

  always_ff @(posedge clk) begin
    if (acc && req_we && !req_err && !th_hit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Load data is resolved at accept, so only the result is held through WAIT/RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      started   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: begin
          if (acc) begin
            rsp_err   <= req_err;
            rsp_rdata <= (req_we || req_err) ? '0 : rext;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus randomized traffic
// against a byte-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_TOHOST_EN
  logic        tohost_valid;
  logic [31:0] tohost_data;
  logic [31:0] th_model = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mb [DEPTH*4];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
`ifdef DMEM_TOHOST_EN
    ,
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access width/sign from funct3, errors from alignment and range,
  // memory as a flat little-endian byte array.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned size = 4;
    bit sgn = 1'b0;
    bit legal = 1'b1;
    bit th = 1'b0;
    logic [31:0] val = '0;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
`ifdef DMEM_TOHOST_EN
    th = (a >= 32'hFFFF_FFF0) && (a <= 32'hFFFF_FFF3) && (!we || size == 4);
`endif
    er = !legal || (a % size != 0) || ((a >= DEPTH*4) && !th);
    rd = '0;
    if (!er) begin
      for (int unsigned k = 0; k < size; k++) begin
`ifdef DMEM_TOHOST_EN
        if (th) begin
          if (we) th_model[8*k +: 8] = wd[8*k +: 8];
          else val[8*k +: 8] = th_model[8*((a % 4) + k) +: 8];
          continue;
        end
`endif
        if (we) mb[a + k] = wd[8*k +: 8];
        else val[8*k +: 8] = mb[a + k];
      end
      if (!we) begin
        if (sgn && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 1);
        rd = val;
      end
    end
  endfunction

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, WAITC + 1);
  endtask

  task automatic ack();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] erd;
    logic        eer;
    model(we, f3, a, wd, erd, eer);
    send(we, f3, a, wd);
    wait_rsp(tag);
    check({tag, "_rdata"}, rsp_rdata, erd);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, eer});
    ack();
  endtask

  initial begin
    logic [31:0] hold_rd;
    logic        hold_er;
    logic [31:0] erd;
    logic        eer;

    // reset state
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rel_req_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 check("rel_req_ready_high", {31'd0, req_ready}, 32'd1);

    for (int unsigned w = 0; w < 64; w++) xact("init", 1'b1, 3'd2, w * 4, $urandom);

    // directed steps
    xact("sw10", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    xact("lw10", 1'b0, 3'd2, 32'h10, 32'h0);
    check("lw10_const", rsp_rdata, 32'hDEAD_BEEF);
    xact("sb11", 1'b1, 3'd0, 32'h11, 32'h80);
    xact("lb11", 1'b0, 3'd0, 32'h11, 32'h0);
    check("lb11_const", rsp_rdata, 32'hFFFF_FF80);
    xact("lbu11", 1'b0, 3'd4, 32'h11, 32'h0);
    check("lbu11_const", rsp_rdata, 32'h0000_0080);
    xact("lw10b", 1'b0, 3'd2, 32'h10, 32'h0);
    check("lw10b_const", rsp_rdata, 32'hDEAD_80EF);
    xact("sh12", 1'b1, 3'd1, 32'h12, 32'h1234);
    xact("lh12", 1'b0, 3'd1, 32'h12, 32'h0);
    xact("lhu13", 1'b0, 3'd5, 32'h13, 32'h0);
    check("lhu13_err_const", {31'd0, rsp_err}, 32'd1);
    xact("lw10c", 1'b0, 3'd2, 32'h10, 32'h0);
    check("lw10c_const", rsp_rdata, 32'h1234_80EF);
    xact("lw400", 1'b0, 3'd2, 32'h400, 32'h0);
    xact("f3_011", 1'b0, 3'd3, 32'h10, 32'h0);
    xact("sb_f3_100", 1'b1, 3'd4, 32'h14, 32'hFF);
    xact("lw14", 1'b0, 3'd2, 32'h14, 32'h0);

    // backpressure: response held, no new request accepted
    model(1'b0, 3'd2, 32'h10, 32'h0, erd, eer);
    send(1'b0, 3'd2, 32'h10, 32'h0);
    wait_rsp("bp");
    hold_rd = rsp_rdata;
    hold_er = rsp_err;
    check("bp_rdata", hold_rd, erd);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h18; req_funct3 = 3'd2;
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_rdata", rsp_rdata, hold_rd);
      check("bp_hold_err", {31'd0, rsp_err}, {31'd0, hold_er});
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    ack();

    // reset during WAIT: store persists, response dropped
    model(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, erd, eer);
    send(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D);
    #1 rst = 1'b0;
    #1 check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("mid_rel_req_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 check("mid_rel_req_ready_high", {31'd0, req_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    xact("lw20", 1'b0, 3'd2, 32'h20, 32'h0);

`ifdef DMEM_TOHOST_EN
    send(1'b1, 3'd2, 32'hFFFF_FFF0, 32'h1);
    model(1'b1, 3'd2, 32'hFFFF_FFF0, 32'h1, erd, eer);
    check("th_pulse", {31'd0, tohost_valid}, 32'd1);
    check("th_data", tohost_data, 32'd1);
    @(posedge clk);
    #1 check("th_pulse_end", {31'd0, tohost_valid}, 32'd0);
    check("th_sw_err", {31'd0, rsp_err}, 32'd0);
    ack();
    xact("th_lw", 1'b0, 3'd2, 32'hFFFF_FFF0, 32'h0);
    check("th_lw_const", rsp_rdata, 32'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? $urandom : (32'h400 + a);
      xact("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
